// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the single gpr write port between the LSU and the
// MDU writeback paths, registers the winning write, and keeps a pending-write
// scoreboard that drives the RAW/WAW issue stall.
//
// Handshake: a request fires when X_wb_valid & X_wb_ready. Requesters hold
// valid/rd/data stable until fire. Ready is combinational from the valids and
// last_grant and is never high without its valid (and never high in reset).
module gpr_wb_arbiter #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_rd_wen,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  output logic              issue_stall,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              lsu_wb_ready,
  input  logic              mdu_wb_valid,
  input  logic [REG_AW-1:0] mdu_wb_rd,
  input  logic [XLEN-1:0]   mdu_wb_data,
  output logic              mdu_wb_ready,
  output logic              gpr_wen,
  output logic [REG_AW-1:0] gpr_rd,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic [31:0]       busy_vec
);

  localparam logic GRANT_LSU = 1'b0;
  localparam logic GRANT_MDU = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic              gpr_wen_q, gpr_wen_d;
  logic [REG_AW-1:0] gpr_rd_q, gpr_rd_d;
  logic [XLEN-1:0]   gpr_wdata_q, gpr_wdata_d;
  logic [31:0]       busy_q, busy_d;

  logic              grant_lsu, grant_mdu, wb_fire;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              issue_fire;

  // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_lsu = rst_n & lsu_wb_valid & (~mdu_wb_valid | (last_grant_q == GRANT_MDU));
    grant_mdu = rst_n & mdu_wb_valid & (~lsu_wb_valid | (last_grant_q == GRANT_LSU));
    wb_fire   = grant_lsu | grant_mdu;
    sel_rd    = grant_mdu ? mdu_wb_rd   : lsu_wb_rd;
    sel_data  = grant_mdu ? mdu_wb_data : lsu_wb_data;
  end

  assign lsu_wb_ready = grant_lsu;
  assign mdu_wb_ready = grant_mdu;

  // Next state of the output write register and the grant pointer.
  always_comb begin
    last_grant_d = last_grant_q;
    gpr_wen_d    = 1'b0;
    gpr_rd_d     = gpr_rd_q;
    gpr_wdata_d  = gpr_wdata_q;
    if (wb_fire) begin
      last_grant_d = grant_mdu ? GRANT_MDU : GRANT_LSU;
      gpr_wen_d    = (sel_rd != '0);
      gpr_rd_d     = sel_rd;
      gpr_wdata_d  = sel_data;
    end
  end

  // Stall only looks at issue inputs and current busy bits (bit 0 is always clear).
  always_comb begin
    issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                                 (issue_rd_wen & busy_q[issue_rd]));
    issue_fire  = issue_valid & ~issue_stall;
  end

  // Scoreboard: clear on commit, then set on issue so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (gpr_wen_q) busy_d[gpr_rd_q] = 1'b0;
    if (issue_fire & issue_rd_wen & (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any pending write and clears the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_MDU;
      gpr_wen_q    <= 1'b0;
      gpr_rd_q     <= '0;
      gpr_wdata_q  <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gpr_wen_q    <= gpr_wen_d;
      gpr_rd_q     <= gpr_rd_d;
      gpr_wdata_q  <= gpr_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign gpr_wen   = gpr_wen_q;
  assign gpr_rd    = gpr_rd_q;
  assign gpr_wdata = gpr_wdata_q;
  assign busy_vec  = busy_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Testbench for gpr_wb_arbiter: directed steps from the test plan followed by
// randomized traffic, all checked against a behavioural model of the rules.
`timescale 1ns/1ps
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_rd_wen;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        lsu_v, mdu_v;
  logic [4:0]  lsu_rd, mdu_rd;
  logic [63:0] lsu_data, mdu_data;
  logic        lsu_wb_ready, mdu_wb_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_rd;
  logic [63:0] gpr_wdata;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_busy[32];
  int          m_lg;        // 0 = LSU, 1 = MDU
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [63:0] m_wdata;

  // Values observed in the combinational phase of the last step
  logic obs_stall, obs_lsu_rdy, obs_mdu_rdy;
  int   last_g;

  gpr_wb_arbiter #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd_wen(issue_rd_wen),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .lsu_wb_valid(lsu_v), .lsu_wb_rd(lsu_rd), .lsu_wb_data(lsu_data),
    .lsu_wb_ready(lsu_wb_ready),
    .mdu_wb_valid(mdu_v), .mdu_wb_rd(mdu_rd), .mdu_wb_data(mdu_data),
    .mdu_wb_ready(mdu_wb_ready),
    .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
    .busy_vec(busy_vec)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_lg = 1; m_wen = 1'b0; m_rd = '0; m_wdata = '0;
  endtask

  // -1 none, 0 LSU, 1 MDU: a single requester wins, a tie goes to the other one
  function automatic int exp_grant();
    if (lsu_v && mdu_v) return 1 - m_lg;
    if (lsu_v) return 0;
    if (mdu_v) return 1;
    return -1;
  endfunction

  function automatic logic exp_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                           (issue_rd_wen && m_busy[issue_rd]));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One cycle: check combinational outputs, clock, advance model, check registers
  task automatic step();
    int   g;
    logic st;
    #1;
    g  = exp_grant();
    st = exp_stall();
    obs_stall = issue_stall; obs_lsu_rdy = lsu_wb_ready; obs_mdu_rdy = mdu_wb_ready;
    chk("lsu_ready", lsu_wb_ready, 64'(g == 0));
    chk("mdu_ready", mdu_wb_ready, 64'(g == 1));
    chk("issue_stall", issue_stall, 64'(st));
    @(posedge clk);
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (issue_valid && !st && issue_rd_wen && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (g >= 0) begin
      m_rd    = (g == 0) ? lsu_rd : mdu_rd;
      m_wdata = (g == 0) ? lsu_data : mdu_data;
      m_wen   = (m_rd != 0);
      m_lg    = g;
    end else begin
      m_wen = 1'b0;
    end
    last_g = g;
    #1;
    chk("gpr_wen", gpr_wen, m_wen);
    chk("gpr_rd", gpr_rd, m_rd);
    chk("gpr_wdata", gpr_wdata, m_wdata);
    chk("busy_vec", busy_vec, m_busy_vec());
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd_wen = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    lsu_v = 0; mdu_v = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic wen, input logic [4:0] rs1);
    issue_valid = 1; issue_rd_wen = wen; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = 0;
  endtask

  initial begin
    logic [4:0] tie_rd [4];
    tie_rd = '{5'd3, 5'd4, 5'd3, 5'd4};
    idle();
    lsu_rd = 0; mdu_rd = 0; lsu_data = 0; mdu_data = 0;
    m_reset();
    last_g = -1;

    // Reset with both valids and all inputs active
    rst_n = 0;
    lsu_v = 1; mdu_v = 1; lsu_rd = 3; lsu_data = 64'h11; mdu_rd = 4; mdu_data = 64'h22;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpr_wen", gpr_wen, 0);
    chk("rst_lsu_ready", lsu_wb_ready, 0);
    chk("rst_mdu_ready", mdu_wb_ready, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_gpr_rd", gpr_rd, 0);
    chk("rst_gpr_wdata", gpr_wdata, 0);
    rst_n = 1;

    // Tie round-robin: LSU first, then alternate
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_lsu_grant", obs_lsu_rdy, 64'(i % 2 == 0));
      chk("tie_gpr_wen", gpr_wen, 1);
      chk("tie_gpr_rd", gpr_rd, tie_rd[i]);
      chk("tie_gpr_wdata", gpr_wdata, (i % 2 == 0) ? 64'h11 : 64'h22);
    end
    idle();
    step();
    chk("tie_idle_wen", gpr_wen, 0);
    chk("tie_hold_rd", gpr_rd, 4);

    // RAW stall on x5
    do_issue(5, 1, 0);
    step();
    chk("raw_busy5", busy_vec[5], 1);
    do_issue(0, 0, 5);
    step();
    chk("raw_stall_wait", obs_stall, 1);
    lsu_v = 1; lsu_rd = 5; lsu_data = 64'hDEAD;
    step();
    chk("raw_stall_N", obs_stall, 1);
    chk("raw_lsu_fire", obs_lsu_rdy, 1);
    lsu_v = 0;
    step();
    chk("raw_stall_N1", obs_stall, 1);
    chk("raw_busy5_clr", busy_vec[5], 0);
    step();
    chk("raw_stall_N2", obs_stall, 0);
    idle();

    // WAW and x0
    do_issue(0, 1, 0);
    step();
    chk("x0_no_stall", obs_stall, 0);
    chk("x0_no_busy", busy_vec, 0);
    do_issue(7, 1, 0);
    step();
    step();
    chk("waw_stall", obs_stall, 1);
    mdu_v = 1; mdu_rd = 7; mdu_data = 64'h77;
    step();
    mdu_v = 0;
    step();
    chk("waw_commit_stall", obs_stall, 1);
    chk("waw_commit_rd", gpr_rd, 7);
    step();
    chk("waw_release", obs_stall, 0);
    chk("waw_rebusy", busy_vec[7], 1);
    idle();
    lsu_v = 1; lsu_rd = 0; lsu_data = 64'h55;
    step();
    chk("x0_wb_ready", obs_lsu_rdy, 1);
    chk("x0_wb_wen", gpr_wen, 0);
    lsu_v = 0; mdu_v = 1; mdu_rd = 7;
    step();
    idle();
    step();

    // Set/clear collision on x9: set wins
    lsu_v = 1; lsu_rd = 9; lsu_data = 64'h99;
    step();
    lsu_v = 0;
    do_issue(9, 1, 0);
    step();
    chk("coll_busy9", busy_vec[9], 1);
    idle();
    lsu_v = 1;
    step();
    lsu_v = 0;
    step();
    chk("coll_busy9_clr", busy_vec[9], 0);

    // Asynchronous reset mid-stream
    do_issue(12, 1, 0);
    step();
    issue_valid = 0;
    lsu_v = 1; lsu_rd = 3; lsu_data = 64'h33;
    step();
    chk("ar_pre_wen", gpr_wen, 1);
    chk("ar_pre_busy12", busy_vec[12], 1);
    mdu_v = 1;
    rst_n = 0;
    #1;
    chk("ar_gpr_wen", gpr_wen, 0);
    chk("ar_gpr_rd", gpr_rd, 0);
    chk("ar_gpr_wdata", gpr_wdata, 0);
    chk("ar_busy", busy_vec, 0);
    chk("ar_lsu_ready", lsu_wb_ready, 0);
    m_reset();
    idle();
    @(posedge clk); #1;
    rst_n = 1;

    // Randomized traffic; requesters hold their request until it fires
    for (int n = 0; n < 400; n++) begin
      issue_valid  = 1'($urandom_range(0, 1));
      issue_rd_wen = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 7));
      issue_rs1    = 5'($urandom_range(0, 7));
      issue_rs2    = 5'($urandom_range(0, 7));
      if (!lsu_v || last_g == 0) begin
        lsu_v = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = {$urandom, $urandom};
      end
      if (!mdu_v || last_g == 1) begin
        mdu_v = 1'($urandom_range(0, 1)); mdu_rd = 5'($urandom_range(0, 7));
        mdu_data = {$urandom, $urandom};
      end
      last_g = -1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
